phys_reg_free_list: RTL and testbench
=====================================

PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Interface
REQ-001 SHALL take parameter FREE_LIST_DEPTH, default 64 (shared package), meaning number of free-list entries; list covers all physical registers.
REQ-002 SHALL take parameter CHECKPOINT_COLUMNS, default 4 (shared package), meaning number of saved head-pointer columns.
REQ-003 SHALL take parameter NUM_ARCH_REGS, default 32 (shared package), meaning number of physical tags held by the architectural map at reset and therefore not free.
REQ-004 Port CLK, input, 1, meaning the single clock; all state updates on rising edge.
REQ-005 Port RST, input, 1, meaning reset; synchronous, active-high.
REQ-006 Port dequeue_valid, input, 1, meaning the rename stage consumes the head tag this cycle.
REQ-007 Port dequeue_ready, output, 1, meaning the list is non-empty and dequeue_phys_reg_tag is valid.
REQ-008 Port dequeue_phys_reg_tag, output, PHYS_REG_WIDTH (6), meaning the tag at the head.
REQ-009 Port enqueue_valid, input, 1, meaning a committed tag is returned to the list.
REQ-010 Port enqueue_phys_reg_tag, input, 6, meaning the tag being freed.
REQ-011 Port save_checkpoint_valid, input, 1, meaning capture the head pointer into a column.
REQ-012 Port save_checkpoint_column, input, LOG_CHECKPOINT_COLUMNS (2), meaning the destination column.
REQ-013 Port restore_checkpoint_valid, input, 1, meaning roll the head pointer back to a column.
REQ-014 Port restore_checkpoint_column, input, 2, meaning the source column.
REQ-015 Port free_count, output, LOG_FREE_LIST_DEPTH+1 (7), meaning the number of free tags currently held.

Function
REQ-016 SHALL be a circular FIFO of FREE_LIST_DEPTH 6-bit entries with head and tail pointers, each LOG_FREE_LIST_DEPTH+1 bits; the extra MSB distinguishes full from empty.
REQ-017 free_count SHALL equal tail minus head, modulo 2^7.
REQ-018 dequeue_ready SHALL be 1 exactly when free_count != 0.
REQ-019 dequeue_phys_reg_tag SHALL be combinational from the head entry, with no enqueue bypass: a tag enqueued into an empty list is visible the next cycle.
REQ-020 A dequeue SHALL take effect only when dequeue_valid and dequeue_ready are both 1; head then increments by 1.
REQ-021 Dequeue while empty SHALL be ignored, with no pointer change.
REQ-022 An enqueue SHALL write the tag at tail and increment tail when enqueue_valid=1 and free_count<FREE_LIST_DEPTH.
REQ-023 Enqueue when full SHALL be dropped with no overwrite; the verification bench flags it as an error.
REQ-024 Simultaneous enqueue and dequeue SHALL both apply, leaving free_count unchanged.
REQ-025 A dequeue and enqueue in the same cycle on an empty list SHALL perform the enqueue only.
REQ-026 Save SHALL write the head pointer into the selected column, taking the value after that cycle's dequeue.
REQ-027 Restore SHALL set head to the stored column value next cycle, overriding any same-cycle dequeue.
REQ-028 Tail SHALL be unaffected by restore, and a same-cycle enqueue still applies.
REQ-029 Save SHALL be ignored when restore is asserted in the same cycle.
REQ-030 Restore SHALL read the column value stored before any same-cycle save.
REQ-031 Pointer increments SHALL wrap naturally at 2^7, and entry index SHALL use the low 6 bits.
REQ-032 Latency SHALL be: dequeue_phys_reg_tag and free_count reflect an operation on the cycle after the edge that applies it.

Reset
REQ-033 On RST, entry i SHALL hold tag NUM_ARCH_REGS+i for i in 0..31; entries 32..63 are don't-care.
REQ-034 On RST, head=0 and tail=32 (free_count=32, dequeue_ready=1, dequeue_phys_reg_tag=32).
REQ-035 On RST, all checkpoint columns SHALL equal 0.
REQ-036 RST asserted mid-operation SHALL override all same-cycle requests.

Structure
REQ-037 FREE_LIST_DEPTH, LOG_FREE_LIST_DEPTH, CHECKPOINT_COLUMNS, LOG_CHECKPOINT_COLUMNS, phys_reg_tag_t and checkpoint_column_t SHALL come from core_types_pkg.
REQ-038 A new typedef free_list_ptr_t (LOG_FREE_LIST_DEPTH+1 bits) SHALL be added to core_types_pkg.
REQ-039 The block SHALL be a single module with no sub-modules; the checkpoint array is a local register array of free_list_ptr_t.

Verification
REQ-040 Reset then 32 back-to-back dequeues -> tags 32..63 in order; dequeue_ready falls to 0 after the 32nd dequeue; a 33rd dequeue causes no change.
REQ-041 Empty list, enqueue tag 5 with dequeue_valid=1 -> dequeue is ignored; next cycle dequeue_phys_reg_tag=5, free_count=1.
REQ-042 Save column 2 at head=3, dequeue 4 more tags, restore column 2 -> next cycle head=3, dequeue_phys_reg_tag=35, free_count=29.
REQ-043 Restore column 1 and dequeue in the same cycle -> the dequeue is ignored; save and restore in the same cycle -> the save is ignored, and that column is unchanged afterward.
REQ-044 Fill the list to 64 via enqueues, then one more enqueue -> it is dropped; free_count=64; the pointer MSBs differ, with low bits equal.
REQ-045 Assert RST after arbitrary traffic -> next cycle free_count=32, dequeue_phys_reg_tag=32, all columns=0.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core types: free-list sizing, physical register tags and checkpoint columns.
package core_types_pkg;

   localparam int PHYS_REG_WIDTH         = 6;
   localparam int FREE_LIST_DEPTH        = 64;
   localparam int LOG_FREE_LIST_DEPTH    = $clog2(FREE_LIST_DEPTH);
   localparam int CHECKPOINT_COLUMNS     = 4;
   localparam int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS);
   localparam int NUM_ARCH_REGS          = 32;

   typedef logic [PHYS_REG_WIDTH-1:0]         phys_reg_tag_t;
   typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
   // Extra MSB separates a full list from an empty one when the low bits match.
   typedef logic [LOG_FREE_LIST_DEPTH:0]      free_list_ptr_t;
   typedef logic [LOG_FREE_LIST_DEPTH-1:0]    free_list_idx_t;

   // Entry index addressed by a wrapping pointer (the wrap bit is dropped).
   function automatic free_list_idx_t ptr_index(input free_list_ptr_t ptr);
      return ptr[LOG_FREE_LIST_DEPTH-1:0];
   endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular FIFO of free tags with checkpointed head
// pointer so that a mispredicted rename path can roll back its allocations.
module phys_reg_free_list
   import core_types_pkg::phys_reg_tag_t;
   import core_types_pkg::checkpoint_column_t;
   import core_types_pkg::free_list_ptr_t;
   import core_types_pkg::free_list_idx_t;
   import core_types_pkg::ptr_index;
#(
   parameter int FREE_LIST_DEPTH    = core_types_pkg::FREE_LIST_DEPTH,
   parameter int CHECKPOINT_COLUMNS = core_types_pkg::CHECKPOINT_COLUMNS,
   parameter int NUM_ARCH_REGS      = core_types_pkg::NUM_ARCH_REGS
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               dequeue_valid,
   output logic               dequeue_ready,
   output phys_reg_tag_t      dequeue_phys_reg_tag,
   input  logic               enqueue_valid,
   input  phys_reg_tag_t      enqueue_phys_reg_tag,
   input  logic               save_checkpoint_valid,
   input  checkpoint_column_t save_checkpoint_column,
   input  logic               restore_checkpoint_valid,
   input  checkpoint_column_t restore_checkpoint_column,
   output free_list_ptr_t     free_count
);

   // Tags not held by the architectural map at reset sit in entries 0.. onward.
   localparam free_list_ptr_t RESET_TAIL = free_list_ptr_t'(FREE_LIST_DEPTH - NUM_ARCH_REGS);
   localparam free_list_ptr_t FULL_COUNT = free_list_ptr_t'(FREE_LIST_DEPTH);

   phys_reg_tag_t  entries_q [FREE_LIST_DEPTH];
   free_list_ptr_t ckpt_q    [CHECKPOINT_COLUMNS];

   free_list_ptr_t head_q;
   free_list_ptr_t head_d;
   free_list_ptr_t tail_q;
   free_list_ptr_t tail_d;
   free_list_ptr_t head_after_deq_s;
   free_list_ptr_t count_s;
   free_list_idx_t head_idx_s;
   free_list_idx_t tail_idx_s;
   logic           empty_s;
   logic           full_s;
   logic           deq_fire_s;
   logic           enq_fire_s;
   logic           save_fire_s;

   // Occupancy, request qualification and next-state pointers.
   always_comb begin
      count_s          = tail_q - head_q;
      empty_s          = (count_s == free_list_ptr_t'(0));
      full_s           = (count_s == FULL_COUNT);
      deq_fire_s       = dequeue_valid & ~empty_s;
      enq_fire_s       = enqueue_valid & ~full_s;
      // A restore wins over a same-cycle save so the column being read stays intact.
      save_fire_s      = save_checkpoint_valid & ~restore_checkpoint_valid;
      head_idx_s       = ptr_index(head_q);
      tail_idx_s       = ptr_index(tail_q);

      if (deq_fire_s) begin
         head_after_deq_s = head_q + free_list_ptr_t'(1);
      end else begin
         head_after_deq_s = head_q;
      end

      // Restore discards any same-cycle allocation by taking the saved head.
      if (restore_checkpoint_valid) begin
         head_d = ckpt_q[restore_checkpoint_column];
      end else begin
         head_d = head_after_deq_s;
      end

      // Tail only moves on commits; restore never touches it.
      if (enq_fire_s) begin
         tail_d = tail_q + free_list_ptr_t'(1);
      end else begin
         tail_d = tail_q;
      end
   end

   // Head and tail pointer registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q <= free_list_ptr_t'(0);
         tail_q <= RESET_TAIL;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Checkpoint columns capture the head as it will be after this cycle's dequeue.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
            ckpt_q[c] <= free_list_ptr_t'(0);
         end
      end else if (save_fire_s) begin
         ckpt_q[save_checkpoint_column] <= head_after_deq_s;
      end else begin
         ckpt_q <= ckpt_q;
      end
   end

   // Tag storage: reset seeds the free tags; commits write at tail.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
            entries_q[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
         end
      end else if (enq_fire_s) begin
         entries_q[tail_idx_s] <= enqueue_phys_reg_tag;
      end else begin
         entries_q <= entries_q;
      end
   end

   // Outputs are decoded straight from registered state; no enqueue bypass.
   always_comb begin
      dequeue_ready        = ~empty_s;
      dequeue_phys_reg_tag = entries_q[head_idx_s];
      free_count           = count_s;
   end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed scoreboard bench for phys_reg_free_list.
module tb_phys_reg_free_list;

   logic       CLK = 1'b0;
   logic       RST;
   logic       dequeue_valid;
   logic       dequeue_ready;
   logic [5:0] dequeue_phys_reg_tag;
   logic       enqueue_valid;
   logic [5:0] enqueue_phys_reg_tag;
   logic       save_checkpoint_valid;
   logic [1:0] save_checkpoint_column;
   logic       restore_checkpoint_valid;
   logic [1:0] restore_checkpoint_column;
   logic [6:0] free_count;

   always #5 CLK = ~CLK;

   phys_reg_free_list dut (
      .CLK                       (CLK),
      .RST                       (RST),
      .dequeue_valid             (dequeue_valid),
      .dequeue_ready             (dequeue_ready),
      .dequeue_phys_reg_tag      (dequeue_phys_reg_tag),
      .enqueue_valid             (enqueue_valid),
      .enqueue_phys_reg_tag      (enqueue_phys_reg_tag),
      .save_checkpoint_valid     (save_checkpoint_valid),
      .save_checkpoint_column    (save_checkpoint_column),
      .restore_checkpoint_valid  (restore_checkpoint_valid),
      .restore_checkpoint_column (restore_checkpoint_column),
      .free_count                (free_count)
   );

   typedef struct {
      logic [6:0] cnt;
      logic       rdy;
      logic [5:0] tag;
      string      nm;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   // One stimulus cycle: drive on the falling edge, queue the state expected after the next rising edge.
   task automatic cyc(input logic rst, input logic dv, input logic ev, input logic [5:0] et,
                      input logic sv, input logic [1:0] sc, input logic rv, input logic [1:0] rc,
                      input logic [6:0] ecnt, input logic [5:0] etag, input string nm);
      exp_t e;
      @(negedge CLK);
      RST                       = rst;
      dequeue_valid             = dv;
      enqueue_valid             = ev;
      enqueue_phys_reg_tag      = et;
      save_checkpoint_valid     = sv;
      save_checkpoint_column    = sc;
      restore_checkpoint_valid  = rv;
      restore_checkpoint_column = rc;
      e.cnt = ecnt;
      e.rdy = (ecnt != 7'd0);
      e.tag = etag;
      e.nm  = nm;
      sb_q.push_back(e);
   endtask

   // Monitor: after each rising edge compare the DUT outputs against the oldest expectation.
   always @(posedge CLK) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if (free_count !== e.cnt) begin
            errors++;
            $display("FAIL %s free_count: got %0d expected %0d", e.nm, free_count, e.cnt);
         end
         checks++;
         if (dequeue_ready !== e.rdy) begin
            errors++;
            $display("FAIL %s dequeue_ready: got %0b expected %0b", e.nm, dequeue_ready, e.rdy);
         end
         if (e.rdy) begin
            checks++;
            if (dequeue_phys_reg_tag !== e.tag) begin
               errors++;
               $display("FAIL %s tag: got %0d expected %0d", e.nm, dequeue_phys_reg_tag, e.tag);
            end
         end
      end
   end

   initial begin
      RST = 1'b1;
      dequeue_valid = 1'b0;
      enqueue_valid = 1'b0;
      enqueue_phys_reg_tag = 6'd0;
      save_checkpoint_valid = 1'b0;
      save_checkpoint_column = 2'd0;
      restore_checkpoint_valid = 1'b0;
      restore_checkpoint_column = 2'd0;

      // Reset state
      cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd32, 6'd32, "reset");
      cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd32, 6'd32, "reset");

      // Drain all 32 free tags in order
      for (int k = 0; k < 32; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'(31 - k), 6'(33 + k), "deq_seq");
      end
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd0, 6'd0, "deq_empty");

      // Enqueue into empty list with a concurrent dequeue request
      cyc(1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 2'd0, 1'b0, 2'd0, 7'd1, 6'd5, "enq_empty");
      cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd1, 6'd5, "enq_hold");

      // Checkpoint save and restore
      cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd32, 6'd32, "reset2");
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd31, 6'd33, "deq");
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd30, 6'd34, "deq");
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 2'd2, 1'b0, 2'd0, 7'd29, 6'd35, "deq_save");
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'(28 - k), 6'(36 + k), "deq_spec");
      end
      cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 2'd2, 7'd29, 6'd35, "restore");
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 2'd1, 7'd32, 6'd32, "restore_vs_deq");
      cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 2'd3, 1'b1, 2'd2, 7'd29, 6'd35, "save_vs_restore");
      cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 2'd3, 7'd32, 6'd32, "save_ignored");
      cyc(1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 2'd0, 1'b1, 2'd2, 7'd30, 6'd35, "restore_enq");

      // Fill to full, then overflow
      cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd32, 6'd32, "reset3");
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 6'(i), 1'b0, 2'd0, 1'b0, 2'd0, 7'(33 + i), 6'd32, "fill");
      end
      cyc(1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 2'd0, 1'b0, 2'd0, 7'd64, 6'd32, "overflow");
      cyc(1'b0, 1'b1, 1'b1, 6'd2, 1'b0, 2'd0, 1'b0, 2'd0, 7'd63, 6'd33, "full_both");
      cyc(1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 2'd0, 1'b0, 2'd0, 7'd63, 6'd34, "both");
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 2'd1, 1'b0, 2'd0, 7'd62, 6'd35, "deq_save1");

      // Mid-operation reset overrides every request
      cyc(1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 2'd1, 1'b1, 2'd2, 7'd32, 6'd32, "reset_mid");
      for (int c = 0; c < 4; c++) begin
         cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 2'(c), 7'd32, 6'd32, "ckpt_clear");
      end
      cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd32, 6'd32, "idle");

      // Let the monitor drain the scoreboard, bounded
      for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
         @(negedge CLK);
      end
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
